// File: rtl/burst_ram.sv
// burst_ram: single-port synchronous command RAM fed by the SPI receive
// path. Opcode-tagged words set pointers, write, read, burst-read or
// zero-fill the array. Read data leaves over a valid/ready handshake.
//
// Handshake: a word on dout transfers on any rising edge where tx_valid
// and tx_ready are both 1. tx_valid, once raised, holds (with dout
// stable) until that transfer. Commands on din are taken only on an edge
// with rx_valid=1 while busy=0. A command offered while busy is dropped
// and sets the sticky err flag.
module burst_ram #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 0,
  localparam int P_W      = (ADDR_W > DATA_W) ? ADDR_W : DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [P_W+2:0]   din,
  input  logic             tx_ready,
  output logic [DATA_W-1:0] dout,
  output logic             tx_valid,
  output logic             busy,
  output logic             err,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_HOLD = 2'd1,
    S_CLEAR   = 2'd2
  } state_t;

  localparam logic [2:0] OP_SET_WR = 3'b000;
  localparam logic [2:0] OP_WRITE  = 3'b001;
  localparam logic [2:0] OP_SET_RD = 3'b010;
  localparam logic [2:0] OP_READ   = 3'b011;
  localparam logic [2:0] OP_BURST  = 3'b100;
  localparam logic [2:0] OP_CLEAR  = 3'b101;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] r_remaining;
  logic [DATA_W-1:0] r_dout;
  logic              r_tx_valid;
  logic              r_err;

  logic [2:0]        w_opcode;
  logic [P_W-1:0]    w_payload;
  logic              w_accept;

  assign w_opcode  = din[P_W+2:P_W];
  assign w_payload = din[P_W-1:0];
  assign w_accept  = rx_valid && (r_state == S_IDLE);

  assign dout        = r_dout;
  assign tx_valid    = r_tx_valid;
  assign busy        = (r_state != S_IDLE);
  assign err         = r_err;
  assign o_dbg_state = r_state;

  // Array write port: command writes from IDLE, zero-fill while clearing.
  // Reset suppresses both so a partially cleared array stays as it is.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_accept && (w_opcode == OP_WRITE)) begin
        r_mem[r_wr_addr] <= w_payload[DATA_W-1:0];
      end else if (r_state == S_CLEAR) begin
        r_mem[r_clr_addr] <= '0;
      end
    end
  end

  // Command decode, read streaming and clear sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_clr_addr  <= '0;
      r_remaining <= '0;
      r_dout      <= '0;
      r_tx_valid  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (rx_valid && (r_state != S_IDLE)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_tx_valid <= 1'b0;
          if (rx_valid) begin
            case (w_opcode)
              OP_SET_WR: r_wr_addr <= w_payload[ADDR_W-1:0];
              OP_WRITE: begin
                if (AUTO_INC != 0) r_wr_addr <= r_wr_addr + 1'b1;
              end
              OP_SET_RD: r_rd_addr <= w_payload[ADDR_W-1:0];
              OP_READ: begin
                r_dout      <= r_mem[r_rd_addr];
                r_tx_valid  <= 1'b1;
                r_remaining <= '0;
                if (AUTO_INC != 0) r_rd_addr <= r_rd_addr + 1'b1;
                r_state     <= S_RD_HOLD;
              end
              OP_BURST: begin
                // N=0 wraps to all-ones remaining, i.e. a full-array burst.
                r_dout      <= r_mem[r_rd_addr];
                r_tx_valid  <= 1'b1;
                r_rd_addr   <= r_rd_addr + 1'b1;
                r_remaining <= w_payload[ADDR_W-1:0] - 1'b1;
                r_state     <= S_RD_HOLD;
              end
              OP_CLEAR: begin
                r_clr_addr <= '0;
                r_state    <= S_CLEAR;
              end
              default: r_err <= 1'b1;
            endcase
          end
        end
        S_RD_HOLD: begin
          if (tx_ready) begin
            if (r_remaining == '0) begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_dout      <= r_mem[r_rd_addr];
              r_rd_addr   <= r_rd_addr + 1'b1;
              r_remaining <= r_remaining - 1'b1;
            end
          end
        end
        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == LAST_ADDR) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_ram.sv
// Bench for burst_ram: drives SPI-style commands, keeps a small memory
// and pointer model, pushes expected read words into exp_q and compares
// them against every tx handshake.
module tb_burst_ram;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 256;
  localparam int AUTO_INC  = 1;
  localparam int P_W       = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [P_W+2:0]    din;
  logic              tx_ready;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              busy;
  logic              err;
  logic [1:0]        o_dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_mem [MEM_DEPTH];
  logic [ADDR_W-1:0] m_wr;
  logic [ADDR_W-1:0] m_rd;

  burst_ram #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .AUTO_INC(AUTO_INC)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din),
    .tx_ready(tx_ready), .dout(dout), .tx_valid(tx_valid),
    .busy(busy), .err(err), .o_dbg_state(o_dbg_state)
  );

  // clock / timeout
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: sim time limit reached, act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: act=0x%0h exp=0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // scoreboard: every transfer on the tx side is popped and compared
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {24'd0, dout}, 32'hFFFF_FFFF);
      end else begin
        check("rd_data", {24'd0, dout}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rx_valid = 1'($urandom_range(0, 1));
      din      = 11'($urandom_range(0, 2047));
      tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b0; rx_valid = 1'b0; din = '0; tx_ready = 1'b0;
    m_wr = '0; m_rd = '0;
    exp_q.delete();
    check("rst_dout", {24'd0, dout}, 32'h0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_err", {31'd0, err}, 32'h0);
  endtask

  // one command accepted in IDLE; model updated alongside
  task automatic send_cmd(input logic [2:0] op, input logic [7:0] pl);
    rx_valid = 1'b1;
    din      = {op, pl};
    case (op)
      3'b000: m_wr = pl;
      3'b001: begin m_mem[m_wr] = pl; if (AUTO_INC != 0) m_wr = m_wr + 1'b1; end
      3'b010: m_rd = pl;
      3'b011: begin exp_q.push_back(m_mem[m_rd]); if (AUTO_INC != 0) m_rd = m_rd + 1'b1; end
      3'b100: begin
        for (int i = 0; i < ((pl == 0) ? MEM_DEPTH : int'(pl)); i++) begin
          exp_q.push_back(m_mem[m_rd]);
          m_rd = m_rd + 1'b1;
        end
      end
      3'b101: for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = '0;
      default: ;
    endcase
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int cnt = 0;
    tx_ready = 1'b1;
    while (tx_valid && cnt < 400) begin
      tick();
      cnt++;
    end
    check("drain_bound", {31'd0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
  endtask

  initial begin
    int   cnt;
    logic pat [5];
    rst = 1'b1; rx_valid = 1'b0; din = '0; tx_ready = 1'b0;
    for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = '0;

    // reset
    do_reset();
    check("rst_state", {30'd0, o_dbg_state}, 32'h0);

    // single access with 3 stall cycles
    send_cmd(3'b000, 8'h10);
    send_cmd(3'b001, 8'hA5);
    send_cmd(3'b010, 8'h10);
    send_cmd(3'b011, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check("single_hold_valid", {31'd0, tx_valid}, 32'h1);
      check("single_hold_dout", {24'd0, dout}, 32'hA5);
      check("single_hold_busy", {31'd0, busy}, 32'h1);
      tick();
    end
    check("single_last_valid", {31'd0, tx_valid}, 32'h1);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("single_after_valid", {31'd0, tx_valid}, 32'h0);
    check("single_after_busy", {31'd0, busy}, 32'h0);

    // auto-increment write wrap
    send_cmd(3'b000, 8'hFE);
    for (int i = 1; i <= 4; i++) send_cmd(3'b001, 8'(i));

    // burst N=4 from 0xFE, ready pattern 1,0,1,1,1
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    send_cmd(3'b010, 8'hFE);
    send_cmd(3'b100, 8'h04);
    check("burst_first_dout", {24'd0, dout}, 32'h01);
    for (int i = 0; i < 5; i++) begin
      tx_ready = pat[i];
      if (i == 1) check("burst_stall_dout", {24'd0, dout}, 32'h02);
      if (i == 2) check("burst_held_dout", {24'd0, dout}, 32'h02);
      tick();
    end
    tx_ready = 1'b0;
    check("burst_end_valid", {31'd0, tx_valid}, 32'h0);
    check("burst_end_busy", {31'd0, busy}, 32'h0);
    check("burst_q_empty", 32'(exp_q.size()), 32'h0);

    // clear, with a write offered mid-clear (wr_addr is 0x02 here)
    send_cmd(3'b101, 8'h00);
    cnt = 0;
    while (busy && cnt < 400) begin
      rx_valid = (cnt == 10);
      din      = {3'b001, 8'h77};
      tick();
      cnt++;
    end
    rx_valid = 1'b0;
    check("clear_busy_cycles", 32'(cnt), 32'd256);
    check("clear_err", {31'd0, err}, 32'h1);
    send_cmd(3'b010, 8'h10);
    send_cmd(3'b011, 8'h00);
    drain();
    send_cmd(3'b010, 8'h02);
    send_cmd(3'b011, 8'h00);
    drain();
    send_cmd(3'b010, 8'hFF);
    send_cmd(3'b011, 8'h00);
    drain();

    // reserved opcodes leave pointers alone
    do_reset();
    send_cmd(3'b000, 8'h20);
    send_cmd(3'b001, 8'h5A);
    send_cmd(3'b110, 8'h33);
    check("rsv110_err", {31'd0, err}, 32'h1);
    check("rsv110_busy", {31'd0, busy}, 32'h0);
    send_cmd(3'b111, 8'h44);
    send_cmd(3'b001, 8'h6B);
    send_cmd(3'b010, 8'h20);
    send_cmd(3'b011, 8'h00);
    drain();
    send_cmd(3'b011, 8'h00);
    drain();

    // full-array burst aborted by reset after 5 transfers
    send_cmd(3'b010, 8'h00);
    send_cmd(3'b100, 8'h00);
    check("burst0_q_fill", 32'(exp_q.size()), 32'd256);
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("burst0_q_left", 32'(exp_q.size()), 32'd251);
    check("burst0_valid_mid", {31'd0, tx_valid}, 32'h1);
    rst = 1'b1;
    tx_ready = 1'b0;
    tick();
    check("abort_tx_valid", {31'd0, tx_valid}, 32'h0);
    check("abort_busy", {31'd0, busy}, 32'h0);
    check("abort_err", {31'd0, err}, 32'h0);
    check("abort_dout", {24'd0, dout}, 32'h0);
    rst = 1'b0;
    exp_q.delete();
    m_wr = '0; m_rd = '0;

    // normal operation after abort
    send_cmd(3'b010, 8'h21);
    send_cmd(3'b011, 8'h00);
    drain();
    check("final_q_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
